axi_sram_responder: RTL and testbench

- AXI4 slave endpoint that terminates a 64-bit, 1-bit-ID AXI master bus with an on-chip SRAM window at `BASE_ADDR`.
- Serves as the target side of the same AXI interface that upstream address-remapping blocks drive.
- Handles INCR/FIXED/WRAP bursts, byte strobes, and decode errors.
- Read and write channels run independently.

---
 rtl/axi_sram_pkg.sv | 43 ++++
 rtl/axi_sram_ram.sv | 35 +++
 rtl/axi_sram_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI4 SRAM responder.
// Holds the AXI burst/response encodings, bus widths, the FSM state types
// and the per-beat address sequencing function used by both channels.
package axi_sram_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;
   localparam int ID_W   = 1;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_BUSY}         r_state_t;

   // Address of the next beat. The step is always one 64-bit word, whatever
   // the transfer size. WRAP is only honoured for 2/4/8/16-beat bursts;
   // any other length (and the reserved burst code) steps like INCR.
   function automatic logic [ADDR_W-1:0] axi_next_addr(input logic [ADDR_W-1:0] addr,
                                                       input logic [7:0]        len,
                                                       input logic [1:0]        burst);
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] mask;
      incr = addr + ADDR_W'(8);
      // (len+1)*8-1 for len = 2^n-1
      mask = {{(ADDR_W-11){1'b0}}, len, 3'b111};
      if (burst == AXI_BURST_FIXED) begin
         return addr;
      end else if (burst == AXI_BURST_WRAP &&
                   (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
         return (addr & ~mask) | (incr & mask);
      end else begin
         return incr;
      end
   endfunction

endpackage

// File: rtl/axi_sram_ram.sv
// Simple dual-port RAM backing the responder window.
// Ports: clock; write port (we, waddr, wdata, wstrb with one enable per
// byte); read port (re, raddr) with rdata registered one cycle after re.
// A read and write to the same word in one cycle returns the old word.
module axi_sram_ram
   import axi_sram_pkg::*;
#(
   parameter int DEPTH = 8192,
   parameter int IDX_W = 13
) (
   input  logic              clock,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave endpoint terminating a 64-bit, 1-bit-ID bus on an on-chip SRAM
// window of MEM_BYTES bytes at BASE_ADDR.
// Ports: clock/reset (synchronous, active-high); AW/W/B write channels and
// AR/R read channels (s_axi_*). lock/cache/prot/qos/size are accepted and
// ignored. Addresses outside the window answer DECERR; write bursts whose
// beat count disagrees with len answer SLVERR. One transaction per direction
// is outstanding at a time; read and write channels are independent.
module axi_sram_responder
   import axi_sram_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int                MEM_BYTES = 65536,
   parameter int                RD_SKID   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ID_W-1:0]   s_axi_awid,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic              s_axi_awlock,
   input  logic [3:0]        s_axi_awcache,
   input  logic [2:0]        s_axi_awprot,
   input  logic [3:0]        s_axi_awqos,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0] s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [ID_W-1:0]   s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ID_W-1:0]   s_axi_arid,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]        s_axi_arlen,
   input  logic [2:0]        s_axi_arsize,
   input  logic [1:0]        s_axi_arburst,
   input  logic              s_axi_arlock,
   input  logic [3:0]        s_axi_arcache,
   input  logic [2:0]        s_axi_arprot,
   input  logic [3:0]        s_axi_arqos,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [ID_W-1:0]   s_axi_rid,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rlast,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);

   localparam int OFF_W = $clog2(MEM_BYTES);
   localparam int IDX_W = OFF_W - 3;
   localparam int DEPTH = MEM_BYTES / 8;
   localparam int CNT_W = $clog2(RD_SKID + 1);
   localparam int PTR_W = (RD_SKID > 1) ? $clog2(RD_SKID) : 1;

   function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W];
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RD_SKID - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awsize,
                            s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arsize};

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   w_state_t          w_state, w_state_nx;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_len;
   logic [1:0]        w_burst;
   logic              w_hit;
   logic              w_err;
   logic [8:0]        w_beat;
   logic              aw_hs, w_hs, ram_we;

   assign s_axi_awready = ~reset & (w_state == W_IDLE);
   assign s_axi_wready  = ~reset & (w_state == W_DATA);
   assign s_axi_bvalid  = ~reset & (w_state == W_RESP);
   assign s_axi_bid     = s_axi_bvalid ? w_id : '0;
   assign s_axi_bresp   = ~s_axi_bvalid ? AXI_RESP_OKAY   :
                          ~w_hit        ? AXI_RESP_DECERR :
                          w_err         ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

   assign aw_hs  = s_axi_awvalid & s_axi_awready;
   assign w_hs   = s_axi_wvalid & s_axi_wready;
   // Beats past len+1 are swallowed without touching the RAM.
   assign ram_we = w_hs & w_hit & (w_beat <= {1'b0, w_len});

   always_comb begin
      w_state_nx = w_state;
      case (w_state)
         W_IDLE:  if (s_axi_awvalid)               w_state_nx = W_DATA;
         W_DATA:  if (s_axi_wvalid && s_axi_wlast) w_state_nx = W_RESP;
         W_RESP:  if (s_axi_bready)                w_state_nx = W_IDLE;
         default:                                  w_state_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_hit   <= 1'b0;
         w_err   <= 1'b0;
         w_beat  <= '0;
      end else begin
         w_state <= w_state_nx;
         if (aw_hs) begin
            w_id   <= s_axi_awid;
            w_hit  <= addr_hit(s_axi_awaddr);
            w_err  <= 1'b0;
            w_beat <= '0;
         end
         if (w_hs) begin
            if (w_beat > {1'b0, w_len})                 w_err <= 1'b1;
            if (s_axi_wlast && w_beat < {1'b0, w_len})  w_err <= 1'b1;
            if (w_beat != '1)                           w_beat <= w_beat + 9'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (aw_hs) begin
         w_addr  <= s_axi_awaddr;
         w_len   <= s_axi_awlen;
         w_burst <= s_axi_awburst;
      end else if (w_hs) begin
         w_addr  <= axi_next_addr(w_addr, w_len, w_burst);
      end
   end

   // ------------------------------------------------------------------
   // Read channel, stage p0: issue RAM reads while the skid has room
   // ------------------------------------------------------------------
   r_state_t          r_state, r_state_nx;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len;
   logic [1:0]        r_burst;
   logic              r_hit;
   logic [8:0]        r_rem;
   logic              ar_hs, vld_p0, pop, push;
   logic [DATA_W-1:0] ram_rdata;

   logic              vld_p1, hit_p1, last_p1;

   logic [DATA_W-1:0] skid_data [RD_SKID];
   logic [1:0]        skid_resp [RD_SKID];
   logic              skid_last [RD_SKID];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  skid_count;

   assign s_axi_arready = ~reset & (r_state == R_IDLE);
   assign s_axi_rvalid  = ~reset & (skid_count != '0);
   assign s_axi_rid     = s_axi_rvalid ? r_id              : '0;
   assign s_axi_rdata   = s_axi_rvalid ? skid_data[rd_ptr] : '0;
   assign s_axi_rresp   = s_axi_rvalid ? skid_resp[rd_ptr] : AXI_RESP_OKAY;
   assign s_axi_rlast   = s_axi_rvalid & skid_last[rd_ptr];

   assign ar_hs = s_axi_arvalid & s_axi_arready;
   assign pop   = s_axi_rvalid & s_axi_rready;
   assign push  = vld_p1;
   // A slot freed by this cycle's pop counts as room, which sustains one
   // beat per cycle with a two-entry skid.
   assign vld_p0 = (r_state == R_BUSY) && (r_rem != '0) &&
                   ((int'(skid_count) + int'(vld_p1)) < (RD_SKID + int'(pop)));

   always_comb begin
      r_state_nx = r_state;
      case (r_state)
         R_IDLE:  if (s_axi_arvalid)           r_state_nx = R_BUSY;
         R_BUSY:  if (pop && skid_last[rd_ptr]) r_state_nx = R_IDLE;
         default:                              r_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= R_IDLE;
         r_id       <= '0;
         r_hit      <= 1'b0;
         r_rem      <= '0;
         vld_p1     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         skid_count <= '0;
      end else begin
         r_state <= r_state_nx;
         if (ar_hs) begin
            r_id  <= s_axi_arid;
            r_hit <= addr_hit(s_axi_araddr);
            r_rem <= {1'b0, s_axi_arlen} + 9'd1;
         end else if (vld_p0) begin
            r_rem <= r_rem - 9'd1;
         end
         vld_p1 <= vld_p0;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   skid_count <= skid_count + CNT_W'(1);
            2'b01:   skid_count <= skid_count - CNT_W'(1);
            default: skid_count <= skid_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (ar_hs) begin
         r_addr  <= s_axi_araddr;
         r_len   <= s_axi_arlen;
         r_burst <= s_axi_arburst;
      end else if (vld_p0) begin
         r_addr  <= axi_next_addr(r_addr, r_len, r_burst);
      end
      if (vld_p0) begin
         hit_p1  <= r_hit;
         last_p1 <= (r_rem == 9'd1);
      end
   end

   // ------------------------------------------------------------------
   // Stage p1: RAM word available, push into the skid FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (push) begin
         skid_data[wr_ptr] <= hit_p1 ? ram_rdata : '0;
         skid_resp[wr_ptr] <= hit_p1 ? AXI_RESP_OKAY : AXI_RESP_DECERR;
         skid_last[wr_ptr] <= last_p1;
      end
   end

   axi_sram_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (w_addr[OFF_W-1:3]),
      .wdata (s_axi_wdata),
      .wstrb (s_axi_wstrb),
      .re    (vld_p0 & r_hit),
      .raddr (r_addr[OFF_W-1:3]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed self-checking bench for axi_sram_responder.
module tb_axi_sram_responder;
   import axi_sram_pkg::*;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [ID_W-1:0]   s_axi_awid = '0;
   logic [ADDR_W-1:0] s_axi_awaddr = '0;
   logic [7:0]        s_axi_awlen = '0;
   logic [2:0]        s_axi_awsize = 3'd3;
   logic [1:0]        s_axi_awburst = '0;
   logic              s_axi_awvalid = 1'b0;
   logic              s_axi_awready;
   logic [DATA_W-1:0] s_axi_wdata = '0;
   logic [STRB_W-1:0] s_axi_wstrb = '0;
   logic              s_axi_wlast = 1'b0;
   logic              s_axi_wvalid = 1'b0;
   logic              s_axi_wready;
   logic [ID_W-1:0]   s_axi_bid;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready = 1'b0;
   logic [ID_W-1:0]   s_axi_arid = '0;
   logic [ADDR_W-1:0] s_axi_araddr = '0;
   logic [7:0]        s_axi_arlen = '0;
   logic [2:0]        s_axi_arsize = 3'd3;
   logic [1:0]        s_axi_arburst = '0;
   logic              s_axi_arvalid = 1'b0;
   logic              s_axi_arready;
   logic [ID_W-1:0]   s_axi_rid;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rlast;
   logic              s_axi_rvalid;
   logic              s_axi_rready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] wbuf [16];
   logic [63:0] rexp [16];

   always #5 clock = ~clock;

   axi_sram_responder dut (
      .clock(clock), .reset(reset),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
      .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
      .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [7:0] strb,
                           input bit stall, input logic [1:0] exp_resp, input string tag);
      int  t;
      bit  seen;
      @(negedge clock);
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      t = 0;
      while (!s_axi_awready && t < 100) begin @(negedge clock); t++; end
      check({tag, " aw_timeout"}, s_axi_awready, 1'b1);
      @(negedge clock);
      s_axi_awvalid = 1'b0;
      check({tag, " wready_lat"}, s_axi_wready, 1'b1);
      for (int i = 0; i < nbeats; i++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = strb;
         s_axi_wlast = (i == nbeats - 1);
         t = 0;
         while (!s_axi_wready && t < 100) begin @(negedge clock); t++; end
         @(negedge clock);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      check({tag, " bvalid_lat"}, s_axi_bvalid, 1'b1);
      s_axi_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      t = 0; seen = 1'b0;
      while (!(s_axi_bvalid && s_axi_bready) && t < 100) begin
         if (s_axi_bvalid) seen = 1'b1;
         @(negedge clock); t++;
         if (seen) check({tag, " bvalid_held"}, s_axi_bvalid, 1'b1);
         if (stall) s_axi_bready = 1'($urandom_range(0, 1));
      end
      check({tag, " b_timeout"}, s_axi_bvalid, 1'b1);
      check({tag, " bresp"}, s_axi_bresp, exp_resp);
      check({tag, " bid"}, s_axi_bid, id);
      @(negedge clock);
      s_axi_bready = 1'b0;
      check({tag, " bvalid_clear"}, s_axi_bvalid, 1'b0);
   endtask

   task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nexp, input logic [1:0] exp_resp,
                          input bit stall, input string tag);
      int          t, k, beat, first;
      bit          held;
      logic [63:0] held_data;
      @(negedge clock);
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      t = 0;
      while (!s_axi_arready && t < 100) begin @(negedge clock); t++; end
      check({tag, " ar_timeout"}, s_axi_arready, 1'b1);
      @(negedge clock);
      s_axi_arvalid = 1'b0;
      s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      k = 0; beat = 0; first = -1; held = 1'b0; held_data = '0;
      while (beat < nexp && k < 300) begin
         if (s_axi_rvalid) begin
            if (held) check({tag, " rdata_held"}, s_axi_rdata, held_data);
            if (first < 0) first = k;
            if (s_axi_rready) begin
               check($sformatf("%s beat%0d data", tag, beat), s_axi_rdata, rexp[beat]);
               check($sformatf("%s beat%0d rresp", tag, beat), s_axi_rresp, exp_resp);
               check($sformatf("%s beat%0d rlast", tag, beat), s_axi_rlast, beat == nexp - 1);
               check($sformatf("%s beat%0d rid", tag, beat), s_axi_rid, id);
               if (!stall) check($sformatf("%s beat%0d slot", tag, beat), k, first + beat);
               beat++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               held_data = s_axi_rdata;
            end
         end else if (held) begin
            check({tag, " rvalid_dropped"}, s_axi_rvalid, 1'b1);
         end
         @(negedge clock); k++;
         if (stall) s_axi_rready = 1'($urandom_range(0, 1));
      end
      s_axi_rready = 1'b0;
      check({tag, " beats"}, beat, nexp);
      if (!stall) check({tag, " rvalid_lat"}, first, 2);
      check({tag, " rvalid_after"}, s_axi_rvalid, 1'b0);
      check({tag, " arready_after"}, s_axi_arready, 1'b1);
   endtask

   initial begin
      int acc, t;
      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst awready", s_axi_awready, 1'b0);
      check("rst arready", s_axi_arready, 1'b0);
      check("rst wready", s_axi_wready, 1'b0);
      check("rst bvalid", s_axi_bvalid, 1'b0);
      check("rst rvalid", s_axi_rvalid, 1'b0);
      reset = 1'b0;
      #1;
      check("post_rst awready", s_axi_awready, 1'b1);
      check("post_rst arready", s_axi_arready, 1'b1);
      check("post_rst rdata", s_axi_rdata, 64'd0);
      check("post_rst rlast", s_axi_rlast, 1'b0);
      check("post_rst bresp", s_axi_bresp, 2'b00);

      // single beat
      wbuf[0] = 64'h1122_3344_5566_7788;
      do_write(1'b1, 32'h1000_0010, 8'd0, AXI_BURST_INCR, 1, 8'hFF, 1'b0, 2'b00, "single_wr");
      rexp[0] = 64'h1122_3344_5566_7788;
      do_read(1'b1, 32'h1000_0010, 8'd0, AXI_BURST_INCR, 1, 2'b00, 1'b0, "single_rd");

      // INCR len 3
      for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i); rexp[i] = 64'(i); end
      do_write(1'b0, 32'h1000_0100, 8'd3, AXI_BURST_INCR, 4, 8'hFF, 1'b0, 2'b00, "incr_wr");
      do_read(1'b0, 32'h1000_0100, 8'd3, AXI_BURST_INCR, 4, 2'b00, 1'b0, "incr_rd");

      // WRAP len 3 starting at 0x118
      rexp[0] = 64'd3; rexp[1] = 64'd0; rexp[2] = 64'd1; rexp[3] = 64'd2;
      do_read(1'b0, 32'h1000_0118, 8'd3, AXI_BURST_WRAP, 4, 2'b00, 1'b0, "wrap_rd");

      // FIXED len 1 reads the same word twice
      rexp[0] = 64'h1122_3344_5566_7788; rexp[1] = 64'h1122_3344_5566_7788;
      do_read(1'b1, 32'h1000_0010, 8'd1, AXI_BURST_FIXED, 2, 2'b00, 1'b0, "fixed_rd");

      // byte strobes
      wbuf[0] = 64'd0;
      do_write(1'b0, 32'h1000_0200, 8'd0, AXI_BURST_INCR, 1, 8'hFF, 1'b0, 2'b00, "strb_clr");
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(1'b0, 32'h1000_0200, 8'd0, AXI_BURST_INCR, 1, 8'h0F, 1'b0, 2'b00, "strb_wr");
      rexp[0] = 64'h0000_0000_FFFF_FFFF;
      do_read(1'b0, 32'h1000_0200, 8'd0, AXI_BURST_INCR, 1, 2'b00, 1'b0, "strb_rd");

      // decode miss; 0x2000_0000 aliases word 0 of the window by its low bits
      wbuf[0] = 64'hA5A5_A5A5_A5A5_A5A5;
      do_write(1'b0, 32'h1000_0000, 8'd0, AXI_BURST_INCR, 1, 8'hFF, 1'b0, 2'b00, "miss_pre");
      wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      do_write(1'b1, 32'h2000_0000, 8'd0, AXI_BURST_INCR, 1, 8'hFF, 1'b0, 2'b11, "miss_wr");
      rexp[0] = 64'd0; rexp[1] = 64'd0;
      do_read(1'b1, 32'h2000_0000, 8'd1, AXI_BURST_INCR, 2, 2'b11, 1'b0, "miss_rd");
      rexp[0] = 64'hA5A5_A5A5_A5A5_A5A5;
      do_read(1'b0, 32'h1000_0000, 8'd0, AXI_BURST_INCR, 1, 2'b00, 1'b0, "miss_unchanged");

      // INCR running off the window end wraps to its start
      wbuf[0] = 64'hC0C0_0000_0000_00C0; wbuf[1] = 64'hC1C1_0000_0000_00C1;
      do_write(1'b0, 32'h1000_FFF8, 8'd1, AXI_BURST_INCR, 2, 8'hFF, 1'b0, 2'b00, "edge_wr");
      rexp[0] = wbuf[0]; rexp[1] = wbuf[1];
      do_read(1'b0, 32'h1000_FFF8, 8'd1, AXI_BURST_INCR, 2, 2'b00, 1'b0, "edge_rd");
      rexp[0] = wbuf[1];
      do_read(1'b0, 32'h1000_0000, 8'd0, AXI_BURST_INCR, 1, 2'b00, 1'b0, "edge_word0");

      // early wlast: len 3 with only 2 beats
      for (int i = 0; i < 4; i++) wbuf[i] = 64'h5555;
      do_write(1'b0, 32'h1000_0300, 8'd3, AXI_BURST_INCR, 4, 8'hFF, 1'b0, 2'b00, "short_pre");
      wbuf[0] = 64'hA1; wbuf[1] = 64'hA2;
      do_write(1'b1, 32'h1000_0300, 8'd3, AXI_BURST_INCR, 2, 8'hFF, 1'b0, 2'b10, "short_wr");
      rexp[0] = 64'hA1; rexp[1] = 64'hA2; rexp[2] = 64'h5555; rexp[3] = 64'h5555;
      do_read(1'b0, 32'h1000_0300, 8'd3, AXI_BURST_INCR, 4, 2'b00, 1'b0, "short_rd");

      // extra beat: len 0 with 2 beats, second beat dropped
      wbuf[0] = 64'h6666; wbuf[1] = 64'h6666;
      do_write(1'b0, 32'h1000_0380, 8'd1, AXI_BURST_INCR, 2, 8'hFF, 1'b0, 2'b00, "long_pre");
      wbuf[0] = 64'hB0; wbuf[1] = 64'hB1;
      do_write(1'b0, 32'h1000_0380, 8'd0, AXI_BURST_INCR, 2, 8'hFF, 1'b0, 2'b10, "long_wr");
      rexp[0] = 64'hB0; rexp[1] = 64'h6666;
      do_read(1'b0, 32'h1000_0380, 8'd1, AXI_BURST_INCR, 2, 2'b00, 1'b0, "long_rd");

      // random bready/rready stalls
      for (int i = 0; i < 8; i++) begin
         wbuf[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
         rexp[i] = wbuf[i];
      end
      do_write(1'b1, 32'h1000_0400, 8'd7, AXI_BURST_INCR, 8, 8'hFF, 1'b1, 2'b00, "stall_wr");
      do_read(1'b1, 32'h1000_0400, 8'd7, AXI_BURST_INCR, 8, 2'b00, 1'b1, "stall_rd");

      // reset after 2 of 8 read beats
      @(negedge clock);
      s_axi_arid = 1'b0; s_axi_araddr = 32'h1000_0400; s_axi_arlen = 8'd7;
      s_axi_arburst = AXI_BURST_INCR; s_axi_arvalid = 1'b1;
      @(negedge clock);
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;
      acc = 0; t = 0;
      while (acc < 2 && t < 50) begin
         if (s_axi_rvalid) acc++;
         @(negedge clock); t++;
      end
      check("midrst two_beats", acc, 2);
      reset = 1'b1; s_axi_rready = 1'b0;
      @(negedge clock);
      check("midrst rvalid_in_rst", s_axi_rvalid, 1'b0);
      reset = 1'b0;
      #1;
      check("midrst rvalid", s_axi_rvalid, 1'b0);
      check("midrst arready", s_axi_arready, 1'b1);
      check("midrst bvalid", s_axi_bvalid, 1'b0);
      repeat (4) @(negedge clock);
      check("midrst no_late_beat", s_axi_rvalid, 1'b0);
      wbuf[0] = 64'h0BAD_CAFE_1234_5678;
      do_write(1'b1, 32'h1000_0010, 8'd0, AXI_BURST_INCR, 1, 8'hFF, 1'b0, 2'b00, "postrst_wr");
      rexp[0] = 64'h0BAD_CAFE_1234_5678;
      do_read(1'b1, 32'h1000_0010, 8'd0, AXI_BURST_INCR, 1, 2'b00, 1'b0, "postrst_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
